polar_to_cartesian: RTL and testbench

- Pipelined CORDIC in rotation mode. Converts a polar sample (magnitude, angle) into Cartesian x = r·cos(θ), y = r·sin(θ).
- Inverse companion of the Atan2 angle block, for driving test vectors and doing rotations in the same 18-bit signed datapath.
- Fully pipelined: accepts one sample per enabled cycle, with a fixed latency and a valid flag travelling alongside the data.

---
 rtl/polar_to_cartesian_if.sv | 11 +
 rtl/polar_to_cartesian.sv | 83 ++++++++
 tb/tb_polar_to_cartesian.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/polar_to_cartesian_if.sv
// polar_to_cartesian_if: polar sample in, Cartesian sample out
interface polar_to_cartesian_if;
    logic signed [17:0] magIn;
    logic signed [17:0] thetaIn;
    logic               validIn;
    logic signed [17:0] xOut;
    logic signed [17:0] yOut;
    logic               validOut;
    modport master (output magIn, thetaIn, validIn, input xOut, yOut, validOut);
    modport slave  (input magIn, thetaIn, validIn, output xOut, yOut, validOut);
endinterface

// File: rtl/polar_to_cartesian.sv
// polar_to_cartesian: pipelined rotation-mode CORDIC, (r, theta) -> (r*cos, r*sin)
module polar_to_cartesian #(
    parameter int ITERATIONS = 14,
    parameter int GUARD_BITS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_enable,
    output logic ce_out,
    polar_to_cartesian_if.slave p
);
    localparam int N = ITERATIONS;
    localparam int G = GUARD_BITS;
    localparam int W = 19 + G;
    localparam int ZW = 18 + G;
    // atan(2^-i) in Q2.18, rescaled to the working angle precision
    localparam int ATAN18 [16] = '{205887, 121542, 64220, 32599, 16363, 8189, 4096, 2048,
                                   1024, 512, 256, 128, 64, 32, 16, 8};
    localparam logic signed [W:0] RND = (W+1)'(1 << (G - 1));
    localparam logic signed [W:0] MAXV = (W+1)'(131071);
    localparam logic signed [W:0] MINV = (W+1)'(-131072);

    function automatic logic signed [ZW-1:0] atan_q(input int k);
        return ZW'((ATAN18[k] * (1 << G) + 4) / 8);
    endfunction

    function automatic logic signed [17:0] fin(input logic signed [W-1:0] a, input logic neg);
        logic signed [W:0] t;
        t = (neg ? -{a[W-1], a} : {a[W-1], a}) + RND;
        t = t >>> G;
        return t > MAXV ? 18'sh1ffff : t < MINV ? 18'sh20000 : t[17:0];
    endfunction

    logic signed [35:0]   prod;
    logic signed [17:0]   th_f;
    logic                 fold;
    logic signed [W-1:0]  x [0:N];
    logic signed [W-1:0]  y [0:N];
    logic signed [ZW-1:0] z [0:N-1];
    logic                 n [0:N];
    logic                 v [0:N];

    assign ce_out = clk_enable;

    // angles beyond +-pi/2 are rotated by pi and the result negated at the end
    always_comb begin
        fold = p.thetaIn > 18'sd51472 || p.thetaIn < -18'sd51472;
        th_f = p.thetaIn > 18'sd51472 ? p.thetaIn - 18'sd102944 : fold ? p.thetaIn + 18'sd102944 : p.thetaIn;
        prod = 36'(p.magIn) * 36'(18'sd79594);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= N; k++) begin
                x[k] <= '0;
                y[k] <= '0;
                n[k] <= 1'b0;
                v[k] <= 1'b0;
            end
            for (int k = 0; k < N; k++) z[k] <= '0;
            p.xOut <= '0;
            p.yOut <= '0;
            p.validOut <= 1'b0;
        end else if (clk_enable) begin
            x[0] <= W'(prod >>> (17 - G));
            y[0] <= '0;
            z[0] <= {th_f, {G{1'b0}}};
            n[0] <= fold;
            v[0] <= p.validIn;
            for (int k = 0; k < N; k++) begin
                x[k+1] <= z[k][ZW-1] ? x[k] + (y[k] >>> k) : x[k] - (y[k] >>> k);
                y[k+1] <= z[k][ZW-1] ? y[k] - (x[k] >>> k) : y[k] + (x[k] >>> k);
                n[k+1] <= n[k];
                v[k+1] <= v[k];
            end
            for (int k = 0; k < N - 1; k++)
                z[k+1] <= z[k][ZW-1] ? z[k] + atan_q(k) : z[k] - atan_q(k);
            p.xOut <= fin(x[N], n[N]);
            p.yOut <= fin(y[N], n[N]);
            p.validOut <= v[N];
        end
    end
endmodule

// File: tb/tb_polar_to_cartesian.sv
// tb_polar_to_cartesian: directed and model-checked stimulus for the CORDIC pipeline
module tb_polar_to_cartesian;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk_enable = 1'b1;
    logic ce_out;
    int n_err = 0;
    int n_chk = 0;
    int rm [216];
    int rt [216];
    bit rv [216];
    int cm [6];
    int ct [6];

    polar_to_cartesian_if p();
    polar_to_cartesian dut (.clk(clk), .reset(reset), .clk_enable(clk_enable), .ce_out(ce_out), .p(p));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int got, input real exp);
        real d;
        d = got - exp;
        n_chk++;
        assert (d <= 8.0 && d >= -8.0) else begin
            n_err++;
            $error("FAIL %s got=%0d exp=%0.1f (tol 8)", tag, got, exp);
        end
    endtask

    function automatic real mx(input int m, input int th);
        return m * $cos(th / 32768.0);
    endfunction

    function automatic real my(input int m, input int th);
        return m * $sin(th / 32768.0);
    endfunction

    task automatic run1(input int mag, input int th, input int ex, input int ey, input string tag);
        int lat;
        p.magIn = 18'(mag);
        p.thetaIn = 18'(th);
        p.validIn = 1'b1;
        step();
        lat = 1;
        p.validIn = 1'b0;
        while (p.validOut !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk_eq({tag, "_lat"}, lat, 16);
        chk_near({tag, "_x"}, p.xOut, real'(ex));
        chk_near({tag, "_y"}, p.yOut, real'(ey));
    endtask

    initial begin
        int e;
        int idx;
        int fed;
        p.magIn = 18'sd65536;
        p.thetaIn = '0;
        p.validIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_eq("rst_v", p.validOut, 0);
            chk_eq("rst_x", p.xOut, 0);
            chk_eq("rst_y", p.yOut, 0);
        end
        reset = 1'b0;
        run1(65536, 0, 65536, 0, "th0");
        run1(65536, 51472, 0, 65536, "th90");
        run1(65536, 102944, -65536, 0, "th180");
        run1(65536, -77208, -46341, -46341, "thm135");
        run1(131071, -25736, 92681, -92681, "thm45");
        for (int t = 1; t <= 215; t++) begin
            rv[t] = t <= 200 && $urandom_range(3) != 0;
            rm[t] = t <= 200 ? int'($urandom_range(40000)) : 0;
            rt[t] = t <= 200 ? int'($urandom_range(205888)) - 102944 : 0;
            p.magIn = 18'(rm[t]);
            p.thetaIn = 18'(rt[t]);
            p.validIn = rv[t];
            step();
            if (t >= 16) begin
                chk_eq("rnd_v", p.validOut, int'(rv[t-15]));
                if (rv[t-15]) begin
                    chk_near("rnd_x", p.xOut, mx(rm[t-15], rt[t-15]));
                    chk_near("rnd_y", p.yOut, my(rm[t-15], rt[t-15]));
                end
            end
        end
        e = 0;
        fed = 0;
        for (int c = 0; c < 66; c++) begin
            clk_enable = c % 3 == 0;
            p.validIn = 1'b0;
            if (clk_enable && fed < 5) begin
                fed++;
                cm[fed] = 20000 + fed * 9000;
                ct[fed] = fed * 37000 - 111000;
                p.magIn = 18'(cm[fed]);
                p.thetaIn = 18'(ct[fed]);
                p.validIn = 1'b1;
            end
            step();
            if (clk_enable) e++;
            chk_eq("ce_out", ce_out, int'(clk_enable));
            idx = e - 15;
            chk_eq("ce_v", p.validOut, int'(idx >= 1 && idx <= 5));
            if (idx >= 1 && idx <= 5) begin
                chk_near("ce_x", p.xOut, mx(cm[idx], ct[idx]));
                chk_near("ce_y", p.yOut, my(cm[idx], ct[idx]));
            end
        end
        clk_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p.magIn = 18'sd50000;
            p.thetaIn = 18'(i * 10000);
            p.validIn = 1'b1;
            step();
        end
        reset = 1'b1;
        p.validIn = 1'b0;
        step();
        chk_eq("mid_rst_v", p.validOut, 0);
        chk_eq("mid_rst_x", p.xOut, 0);
        reset = 1'b0;
        run1(65536, 25736, 46341, 46341, "post_rst");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
